// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit LFSR among N_REQ requesters; each grant steps the LFSR once.
// Optional post-reset warmup stepping is enabled by defining RNG_ARB_WARMUP_EN.

module lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] rand_out,
  output logic [WIDTH-1:0] next_c
);

  // Fibonacci form: shift left, feedback is the parity of the tapped bits
  always_comb next_c = {rand_out[WIDTH-2:0], ^(rand_out & TAPS)};

  always_ff @(posedge clk) begin
    if (rst)     rand_out <= SEED;
    else if (en) rand_out <= next_c;
  end

endmodule

module rng_share_arbiter #(
  parameter int unsigned      N_REQ         = 4,
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(8'h01),
  parameter int unsigned      WARMUP_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         rand_data,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy,
  output logic [15:0]              draw_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("rng_share_arbiter: N_REQ must be 2..8");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 65536) begin : g_bad_warmup
    $error("rng_share_arbiter: WARMUP_CYCLES must be 1..65536");
  end

`ifdef RNG_ARB_WARMUP_EN
  typedef enum logic [1:0] {ST_WARMUP, ST_IDLE, ST_STEP, ST_ACK} state_t;
  localparam state_t ST_RESET = ST_WARMUP;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_ACK} state_t;
  localparam state_t ST_RESET = ST_IDLE;
`endif

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_vld;
  logic             lfsr_en;
  logic             grant_ld;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_next;

  lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (lfsr_en),
    .rand_out (lfsr_q),
    .next_c   (lfsr_next)
  );

  // Round-robin pick: first requester found scanning from ptr+1, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef RNG_ARB_WARMUP_EN
  logic [15:0] warm_cnt;
  logic        warm_done;

  assign warm_done = (32'(warm_cnt) + 32'd1) >= WARMUP_CYCLES;

  always_ff @(posedge clk) begin
    if (rst)                    warm_cnt <= '0;
    else if (state == ST_WARMUP) warm_cnt <= warm_cnt + 16'd1;
  end
`endif

  // Next-state and LFSR enable
  always_comb begin
    state_d  = state;
    lfsr_en  = 1'b0;
    grant_ld = 1'b0;
    case (state)
`ifdef RNG_ARB_WARMUP_EN
      ST_WARMUP: begin
        lfsr_en = 1'b1;
        if (warm_done) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (win_vld) begin
          grant_ld = 1'b1;
          state_d  = ST_STEP;
        end
      end
      ST_STEP: begin
        lfsr_en = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_RESET;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // State and registered outputs; ACK-cycle outputs load on the STEP->ACK edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      ptr        <= IDX_W'(N_REQ - 1);
      ack        <= '0;
      rand_data  <= '0;
      grant_idx  <= '0;
      draw_count <= '0;
    end else begin
      state <= state_d;
      ack   <= '0;
      if (grant_ld) grant_idx <= win_idx;
      if (state == ST_STEP) begin
        ack        <= N_REQ'(1) << grant_idx;
        rand_data  <= lfsr_next;
        ptr        <= grant_idx;
        draw_count <= draw_count + 16'd1;
      end
    end
  end

  // An all-zero LFSR would lock up and hand out identical draws
  a_lfsr_live: assert property (@(posedge clk) disable iff (rst) lfsr_q != '0);

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Randomized + directed bench for rng_share_arbiter against a transaction-level reference model.
module tb_rng_share_arbiter;

  localparam int unsigned N = 4;
`ifdef RNG_ARB_WARMUP_EN
  localparam int WARM = 4;
`else
  localparam int WARM = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  ack;
  logic [7:0]  rand_data;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [15:0] draw_count;

  int total = 0;
  int bad   = 0;

  // Reference model: m_left counts remaining non-idle cycles of a grant (2 = step, 1 = ack)
  int         m_left, m_warm, m_ptr, m_grant, m_draws;
  logic [7:0] m_val, m_data;
  int         ack_log[$];

  rng_share_arbiter #(
    .N_REQ         (4),
    .WIDTH         (8),
    .SEED          (8'h01),
    .WARMUP_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .rand_data  (rand_data),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .draw_count (draw_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Polynomial x^8 + x^6 + x^5 + x^4 + 1
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_edge();
    bit found;
    int c;
    if (rst) begin
      m_left = 0; m_warm = WARM; m_ptr = N - 1; m_grant = 0;
      m_draws = 0; m_val = 8'h01; m_data = 8'h00;
    end else if (m_warm > 0) begin
      m_warm--;
      m_val = lfsr_step(m_val);
    end else if (m_left == 2) begin
      m_left  = 1;
      m_val   = lfsr_step(m_val);
      m_data  = m_val;
      m_ptr   = m_grant;
      m_draws = (m_draws + 1) % 65536;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (req != 4'b0000) begin
      found = 1'b0;
      for (int i = 1; i <= int'(N); i++) begin
        c = (m_ptr + i) % int'(N);
        if (!found && req[c]) begin
          found   = 1'b1;
          m_grant = c;
        end
      end
      m_left = 2;
    end
  endtask

  task automatic compare_all();
    check("ack",        32'(ack),        (m_left == 1) ? (32'(1) << m_grant) : 32'(0));
    check("rand_data",  32'(rand_data),  32'(m_data));
    check("grant_idx",  32'(grant_idx),  32'(m_grant));
    check("busy",       32'(busy),       32'((m_left != 0) || (m_warm > 0)));
    check("draw_count", 32'(draw_count), 32'(m_draws));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    for (int i = 0; i < int'(N); i++) if (ack[i] === 1'b1) ack_log.push_back(i);
  endtask

  // Leaves the bench at the start of cycle 0 (rst just released)
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int         exp_idx[5];
  logic [7:0] exp_data[5];

  initial begin
    exp_idx  = '{0, 1, 2, 3, 0};
    exp_data = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    do_reset();
    check("rst_ack",  32'(ack),        32'(0));
    check("rst_data", 32'(rand_data),  32'(0));
    check("rst_cnt",  32'(draw_count), 32'(0));

`ifndef RNG_ARB_WARMUP_EN
    // Single requester: first draw at cycle 2
    req = 4'b0001;
    tick(); tick();
    check("a_ack",  32'(ack),        32'h1);
    check("a_data", 32'(rand_data),  32'h02);
    check("a_cnt",  32'(draw_count), 32'd1);

    // All requesting: one draw per three cycles in index order
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin tick(); tick(); end
      else begin tick(); tick(); tick(); end
      check("b_ack",  32'(ack),       32'(1) << exp_idx[k]);
      check("b_data", 32'(rand_data), 32'(exp_data[k]));
    end

    // Requesters 0 and 2 alternate
    do_reset();
    ack_log.delete();
    req = 4'b0101;
    repeat (12) tick();
    check("c_nack", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      check("c_seq0", 32'(ack_log[0]), 32'd0);
      check("c_seq1", 32'(ack_log[1]), 32'd2);
      check("c_seq2", 32'(ack_log[2]), 32'd0);
      check("c_seq3", 32'(ack_log[3]), 32'd2);
    end

    // Reset during STEP aborts the grant and reseeds
    do_reset();
    req = 4'b0001;
    tick();
    rst = 1'b1;
    tick();
    check("d_ack",  32'(ack),        32'(0));
    check("d_busy", 32'(busy),       32'(0));
    tick();
    rst = 1'b0;
    tick(); tick();
    check("d_ack2", 32'(ack),        32'h1);
    check("d_data", 32'(rand_data),  32'h02);
    check("d_cnt",  32'(draw_count), 32'd1);

    // Dropped request still completes its grant
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    check("e_ack",  32'(ack),  32'h2);
    tick();
    check("e_busy", 32'(busy), 32'(0));
    check("e_idle", 32'(ack),  32'(0));
`else
    // Warmup: four steps while busy, then the fifth draw is granted
    req = 4'b0001;
    check("w_busy0", 32'(busy), 32'(1));
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("w_busy", 32'(busy), 32'(1));
    end
    tick();
    check("w_idle", 32'(busy), 32'(0));
    tick(); tick();
    check("w_ack",  32'(ack),       32'h1);
    check("w_data", 32'(rand_data), 32'h23);
`endif

    // Random request levels with occasional resets
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_share_arbiter.md
# rng_share_arbiter

Shares one instance of the team's 8-bit `lfsr` block among `N_REQ` requesters. Each request is served by stepping the LFSR exactly once and returning the fresh value, so no two requesters ever receive the same draw. Requesters are served in round-robin order. The block sits between game/control FSMs that need random numbers and the single shared `lfsr`, and it owns that instance's `en` and `rst`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; range 2..8.
- `WIDTH`, default 8: LFSR and data width; passed to `lfsr`.
- `SEED`, default 8'h01: LFSR seed; passed to `lfsr`.
- `WARMUP_CYCLES`, default 16: number of post-reset LFSR steps; used only with `RNG_ARB_WARMUP_EN`.

Ports:
- `clk`, in, 1: clock; all logic is on posedge.
- `rst`, in, 1: reset, synchronous, active-high; also drives `lfsr.rst`.
- `req`, in, N_REQ: level request per requester; each grant consumes one draw.
- `ack`, out, N_REQ: one-hot, one-cycle pulse; `rand_data` is valid for `grant_idx` in that cycle.
- `rand_data`, out, WIDTH: registered draw value; holds between grants.
- `grant_idx`, out, $clog2(N_REQ): index of the last or current winner.
- `busy`, out, 1: high in every state except IDLE.
- `draw_count`, out, 16: total acks issued; wraps 16'hFFFF -> 0.

## Operation
- States: WARMUP (macro only), IDLE, STEP, ACK.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin, scanning from `ptr+1` modulo N_REQ.
  - Register the winner into `grant_idx`, then go to STEP.
  - If no `req` bit is high, stay in IDLE.
- STEP:
  - `lfsr.en`=1 for exactly this cycle; the LFSR value updates at the end of the cycle.
  - Always go to ACK.
- ACK:
  - `ack[grant_idx]`=1 and `rand_data` = the new `lfsr.rand_out`.
  - Set `ptr`<=`grant_idx` and increment `draw_count`.
  - Always go to IDLE.
- `lfsr.en`=0 in all other states.
- `req` is sampled only in IDLE. Changes to `req` during STEP/ACK do not cancel the grant in flight; if the requester drops `req`, the ack still pulses and the draw is counted.
- A requester that holds `req` through `ack` is re-requesting. Round-robin guarantees that other pending requesters are served before it again.
- Reset values:
  - state = IDLE (WARMUP with the macro), `ptr` = N_REQ-1 (so requester 0 is served first).
  - `ack`=0, `rand_data`=0, `grant_idx`=0, `draw_count`=0.
  - `busy`=0 without the macro, 1 with it.
- Reset mid-operation (STEP or ACK): the grant is aborted with no ack, the LFSR reloads `SEED`, and `draw_count` clears.

## Timing
- Cycle 0 is the first cycle with `rst`=0.
- Latency: `req` high in IDLE cycle t -> STEP at t+1 -> `ack` at t+2.
- Throughput: one draw per 3 cycles with continuous requests.
- `ack`, `rand_data`, `grant_idx` and `draw_count` are registered. `busy` is decoded from the state register.
- `rand_data` changes only on entry to ACK.

## Configuration
- Macro: `RNG_ARB_WARMUP_EN`.
- Defined:
  - After reset the FSM starts in WARMUP with `lfsr.en`=1 for WARMUP_CYCLES consecutive cycles, then enters IDLE.
  - `busy`=1 throughout WARMUP; `req` is ignored but not lost, because it is level-held.
  - A 16-bit warmup counter exists.
- Undefined: no WARMUP state and no warmup counter; the FSM resets to IDLE and WARMUP_CYCLES is unused.

## Test plan
- No macro, SEED=8'h01, `req`=4'b0001 from cycle 0: `ack`=4'b0001 at cycle 2 with `rand_data`=8'h02, `draw_count`=1.
- No macro, `req`=4'b1111 held: acks at cycles 2, 5, 8, 11, 14 go to requesters 0, 1, 2, 3, 0 with data 8'h02, 8'h04, 8'h08, 8'h11, 8'h23.
- `req`=4'b0101 held: acks alternate 0, 2, 0, 2; requesters 1 and 3 never ack; `busy` drops only in IDLE cycles.
- `rst` asserted during STEP of the first grant: no ack; after release, the next grant returns 8'h02 and `draw_count` is 1.
- `req[1]` raised in cycle 0 and dropped in cycle 1: `ack[1]` still pulses at cycle 2, then IDLE with `busy`=0.
- With `RNG_ARB_WARMUP_EN`, WARMUP_CYCLES=4, `req`=4'b0001 from cycle 0: `busy`=1 in cycles 0-3, ack at cycle 6 with `rand_data`=8'h23.
